decoder8_rr_arbiter: RTL and testbench
======================================

DECODER8_RR_ARBITER -- requirements
Module: decoder8_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15, SHALL set the maximum number of cycles a single grant is held (range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 en  input  1  SHALL be the arbiter enable; en=0 forbids new grants and drops an active grant.
REQ-005 req  input  8  SHALL carry one request bit per requester 0..7.
REQ-006 done  input  1  SHALL be the one-cycle release pulse from the current grant holder.
REQ-007 gnt_valid  output  1  SHALL be high while a grant is active.
REQ-008 gnt_idx  output  3  SHALL carry the binary index of the granted requester; 0 when gnt_valid=0.
REQ-009 Y  output  8  SHALL be the one-hot decode of gnt_idx (Y[gnt_idx]=1) when gnt_valid=1, all zeros otherwise.
REQ-010 timeout  output  1  SHALL pulse high for one cycle when a grant is force-released by the hold limit.

Function
REQ-011 The block SHALL implement two states: IDLE and GRANT.
REQ-012 Internal 3-bit priority pointer ptr SHALL name the highest-priority requester; search order ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-013 In IDLE with en=1 and req!=0, the first requester in search order SHALL be granted: GRANT entered and gnt_valid, gnt_idx, Y registered on the next edge (1-cycle latency from request to grant).
REQ-014 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with all outputs 0.
REQ-015 In GRANT, outputs SHALL remain constant until a release event.
REQ-016 Release events SHALL be: done=1; req[gnt_idx]=0; en=0; hold counter reaching HOLD_MAX (if compiled in).
REQ-017 On any release, the next state SHALL be IDLE, outputs 0 on the next edge, and ptr SHALL become gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-018 A released requester SHALL NOT be re-granted in the cycle it is released; the earliest new grant occurs 1 cycle after IDLE is entered (minimum 1 idle cycle between grants).
REQ-019 Simultaneous release events SHALL be treated as one release; timeout SHALL pulse only when the hold limit is reached and done=0, req[gnt_idx]=1, en=1.
REQ-020 Hold counter SHALL be 8 bits, cleared on grant, incremented each GRANT cycle, never wrapping (saturates at HOLD_MAX).
REQ-021 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect on the current grant.
REQ-022 done SHALL be ignored in IDLE.

Reset
REQ-023 On rst=1 at a clock edge, state SHALL become IDLE, ptr=0, hold counter=0, and gnt_valid, gnt_idx, Y, timeout SHALL all be 0 on that edge.
REQ-024 rst SHALL take precedence over every other input, including mid-grant; the first grant after reset follows the search order from requester 0.

Configuration
REQ-025 Macro ARB_HOLD_TIMEOUT_EN defined: hold counter and timeout release per REQ-016/019/020 are present.
REQ-026 Macro ARB_HOLD_TIMEOUT_EN undefined: no hold counter is built, grants end only on done, req[gnt_idx]=0 or en=0, and timeout is tied to 0.

Verification
REQ-027 rst=1 for 2 cycles with req=8'hFF, en=1 -> all outputs 0; after rst release, grant on cycle+1 with gnt_idx=0, Y=8'h01.
REQ-028 en=1, req=8'b1000_0101 held, done pulsed 2 cycles into each grant -> grant order 0, 2, 7, 0 with one idle cycle between grants; Y=8'h01, 8'h04, 8'h80, 8'h01.
REQ-029 Grant to 7 then released -> ptr wraps to 0; with req=8'h81 next grant is 0, not 7.
REQ-030 HOLD_MAX=4, ARB_HOLD_TIMEOUT_EN defined, req=8'h08 held, no done -> gnt_idx=3 for 4 cycles, timeout=1 on the release edge, then IDLE, then re-grant 3.
REQ-031 Same stimulus with ARB_HOLD_TIMEOUT_EN undefined -> gnt_idx=3 held for 50+ cycles, timeout constantly 0.
REQ-032 Mid-grant en=0 (or rst=1) -> gnt_valid=0, Y=8'h00 next edge; with rst, next grant starts from requester 0; with en, from gnt_idx+1.

Source files
------------

// File: rtl/decoder8_rr_arbiter.sv
// decoder8_rr_arbiter: 8-way round-robin arbiter with registered binary index and one-hot grant.
// Define ARB_HOLD_TIMEOUT_EN to build the HOLD_MAX hold counter and the timeout release.
module decoder8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] Y,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic [7:0] y_q;
  logic       timeout_q;

  logic [7:0] rot_req;
  logic [2:0] off_d;
  logic [2:0] pick_d;
  logic       hold_hit;
  logic       other_rel;
  logic       release_d;

  // Rotate so bit 0 is the pointer position; lowest set bit is the winner.
  always_comb begin
    rot_req = 8'({req, req} >> ptr_q);
    off_d   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) off_d = 3'(k);
    end
  end

  assign pick_d    = ptr_q + off_d;
  assign other_rel = done | ~req[idx_q] | ~en;
  assign release_d = other_rel | hold_hit;

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_q;
  logic [7:0] hold_inc;

  assign hold_inc = (hold_q == 8'(HOLD_MAX)) ? hold_q : hold_q + 8'd1;
  assign hold_hit = (hold_inc == 8'(HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 8'd0;
    end else if (state_q == IDLE) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_inc;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      y_q       <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && (req != 8'd0)) begin
            state_q <= GRANT;
            valid_q <= 1'b1;
            idx_q   <= pick_d;
            y_q     <= 8'd1 << pick_d;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= 3'd0;
            y_q       <= 8'd0;
            ptr_q     <= idx_q + 3'd1;
            timeout_q <= hold_hit & ~other_rel;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign Y         = y_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_decoder8_rr_arbiter.sv
// Self-checking bench for decoder8_rr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the round-robin rules.
module tb_decoder8_rr_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic       done = 1'b0;
  logic [7:0] req  = 8'd0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] Y;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_hold = 0;
  bit m_to   = 1'b0;

  decoder8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .done     (done),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .Y        (Y),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit found;
    bit other;
    bit hit;
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (en && req != 8'd0) begin
          found = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (!found && req[(m_ptr + i) % 8]) begin
              found  = 1'b1;
              m_idx  = (m_ptr + i) % 8;
            end
          end
          m_busy = 1'b1;
          m_hold = 0;
        end
      end else begin
        other = done || !req[m_idx] || !en;
        hit   = TO_EN && (m_hold + 1 >= HOLD);
        if (other || hit) begin
          m_busy = 1'b0;
          m_ptr  = (m_idx + 1) % 8;
          m_to   = hit && !other;
          m_idx  = 0;
        end else begin
          m_hold = m_hold + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [12:0] exp_out();
    logic [7:0] y;
    logic [2:0] ix;
    ix = m_busy ? 3'(m_idx) : 3'd0;
    y  = m_busy ? (8'd1 << ix) : 8'd0;
    return {m_busy, ix, y, m_to};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if ({gnt_valid, gnt_idx, Y, timeout} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_outs: got %h required %h", {gnt_valid, gnt_idx, Y, timeout}, 13'd0);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({gnt_valid, gnt_idx, Y, timeout} !== {1'b1, 3'd0, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL first_grant: valid=%b idx=%0d Y=%h required valid=1 idx=0 Y=01",
               gnt_valid, gnt_idx, Y);
    end
    n_checks++;
    if ({gnt_valid, gnt_idx, Y, timeout} !== exp_out()) begin
      n_fail++;
      $display("FAIL first_grant_model: got %h required %h", {gnt_valid, gnt_idx, Y, timeout}, exp_out());
    end
  endtask

  task automatic test_order();
    int         exp_i[4] = '{0, 2, 7, 0};
    logic [7:0] exp_y[4] = '{8'h01, 8'h04, 8'h80, 8'h01};
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; req = 8'b1000_0101; done = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_i[k]) || Y !== exp_y[k]) begin
        n_fail++;
        $display("FAIL order_grant%0d: valid=%b idx=%0d Y=%h required valid=1 idx=%0d Y=%h",
                 k, gnt_valid, gnt_idx, Y, exp_i[k], exp_y[k]);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt_valid !== 1'b0 || Y !== 8'h00 || gnt_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL order_idle%0d: valid=%b idx=%0d Y=%h required all 0", k, gnt_valid, gnt_idx, Y);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; req = 8'h80; done = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7 || Y !== 8'h80) begin
      n_fail++;
      $display("FAIL wrap_grant7: valid=%b idx=%0d Y=%h required 1/7/80", gnt_valid, gnt_idx, Y);
    end
    req = 8'h81; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || Y !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_grant0: valid=%b idx=%0d Y=%h required 1/0/01", gnt_valid, gnt_idx, Y);
    end
  endtask

  task automatic test_hold();
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; req = 8'h08; done = 1'b0;
    tick();
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int c = 0; c < HOLD; c++) begin
      n_checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b idx=%0d timeout=%b required 1/3/0",
                 c, gnt_valid, gnt_idx, timeout);
      end
      tick();
    end
    n_checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b1 || Y !== 8'h00) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b timeout=%b Y=%h required 0/1/00", gnt_valid, timeout, Y);
    end
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_regrant: valid=%b idx=%0d timeout=%b required 1/3/0", gnt_valid, gnt_idx, timeout);
    end
`else
    for (int c = 0; c < 55; c++) begin
      n_checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || Y !== 8'h08 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_no_timeout%0d: valid=%b idx=%0d Y=%h timeout=%b required 1/3/08/0",
                 c, gnt_valid, gnt_idx, Y, timeout);
      end
      tick();
    end
`endif
  endtask

  task automatic test_abort();
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; req = 8'hFF; done = 1'b0;
    tick();
    tick();
    en = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b0 || Y !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_en: valid=%b Y=%h required 0/00", gnt_valid, Y);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1 || Y !== 8'h02) begin
      n_fail++;
      $display("FAIL abort_en_next: valid=%b idx=%0d Y=%h required 1/1/02", gnt_valid, gnt_idx, Y);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({gnt_valid, gnt_idx, Y, timeout} !== 13'd0) begin
      n_fail++;
      $display("FAIL abort_rst: got %h required 0000", {gnt_valid, gnt_idx, Y, timeout});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || Y !== 8'h01) begin
      n_fail++;
      $display("FAIL abort_rst_next: valid=%b idx=%0d Y=%h required 1/0/01", gnt_valid, gnt_idx, Y);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; done = 1'b0; tick();
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 15) != 0);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        req = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      tick();
      n_checks++;
      if ({gnt_valid, gnt_idx, Y, timeout} !== exp_out()) begin
        n_fail++;
        $display("FAIL random_c%0d: got valid=%b idx=%0d Y=%h to=%b required %h",
                 c, gnt_valid, gnt_idx, Y, timeout, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_wrap();
    test_hold();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
